mux21x16_arbiter: RTL and testbench

//   Two-requester arbiter that shares one 16-bit 2:1 operand mux between

---
 rtl/mux21x16_arbiter.sv | 72 +++++++
 tb/tb_mux21x16_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mux21x16_arbiter.sv
// mux21x16_arbiter: round-robin, burst-bounded arbiter that owns the select
// of an external 16-bit 2:1 mux and registers the selected word into a
// valid/ready output stage.
module mux21x16_arbiter #(
   parameter int WIDTH     = 16,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             b_valid,
   output logic             b_ready,
   output logic             sel,
   input  logic [WIDTH-1:0] mux_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   logic             owner;      // requester that received the last grant
   logic [CNT_W-1:0] burst_cnt;  // consecutive grants to owner, saturating
   logic             load;
   logic             pref;
   logic             grant;

   // Output stage can accept a word when empty or draining this cycle.
   assign load = !out_valid || out_ready;

   // The owner keeps priority until its burst is used up.
   assign pref = (burst_cnt == MAX_CNT) ? ~owner : owner;

   // Select: lone requester wins outright; ties and idle follow pref so the
   // select never toggles while idle. Held at A while in reset.
   always_comb begin
      sel = pref;
      if (reset)                  sel = 1'b0;
      else if (a_valid && !b_valid) sel = 1'b0;
      else if (!a_valid && b_valid) sel = 1'b1;
   end

   // Ready only to the selected requester, only when the stage can load.
   assign a_ready = !reset && load && a_valid && !sel;
   assign b_ready = !reset && load && b_valid &&  sel;
   assign grant   = a_ready || b_ready;

   // Capture, drain and burst bookkeeping; reset drops any held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         owner     <= 1'b0;
         burst_cnt <= '0;
      end else if (grant) begin
         out_data  <= mux_out;
         out_valid <= 1'b1;
         if (sel == owner) begin
            if (burst_cnt != MAX_CNT)
               burst_cnt <= burst_cnt + CNT_W'(1);
         end else begin
            owner     <= sel;
            burst_cnt <= CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux21x16_arbiter.sv
// Testbench for mux21x16_arbiter: table of per-cycle vectors with hand-derived
// select/ready expectations, and a scoreboard queue of granted words compared
// against the registered output.
module tb_mux21x16_arbiter;

   logic        clk = 1'b0;
   logic        reset, a_valid, b_valid, out_ready;
   logic        a_ready, b_ready, sel, out_valid;
   logic [15:0] a_data, b_data, mux_out, out_data;

   always #5 clk = ~clk;

   // External mux21x16
   assign mux_out = sel ? b_data : a_data;

   mux21x16_arbiter #(.WIDTH(16), .MAX_BURST(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready),
      .b_valid(b_valid), .b_ready(b_ready),
      .sel(sel), .mux_out(mux_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   typedef struct {
      logic        rst, av, bv, ordy;
      logic [15:0] ad, bd;
      logic        esel, ear, ebr;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] sb[$];
   int          checks = 0;
   int          failures = 0;
   logic        prev_rst = 1'b0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @vec%0d got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rst, av, bv, ordy, input logic [15:0] ad, bd,
                      input logic esel, ear, ebr);
      vec_t v;
      v.rst = rst; v.av = av; v.bv = bv; v.ordy = ordy;
      v.ad = ad; v.bd = bd; v.esel = esel; v.ear = ear; v.ebr = ebr;
      tbl.push_back(v);
   endtask

   // One clock cycle: drive, sample combinational outputs and output stage,
   // update the scoreboard, advance past the edge.
   task automatic step(input vec_t v, input int idx);
      reset = v.rst; a_valid = v.av; b_valid = v.bv; out_ready = v.ordy;
      a_data = v.ad; b_data = v.bd;
      #1;
      chk("a_ready", idx, 32'(a_ready), 32'(v.ear));
      chk("b_ready", idx, 32'(b_ready), 32'(v.ebr));
      if (!v.rst) begin
         chk("sel", idx, 32'(sel), 32'(v.esel));
         chk("out_valid", idx, 32'(out_valid), 32'(sb.size() != 0));
         if (prev_rst) chk("out_data_rst", idx, 32'(out_data), 32'd0);
         if (out_valid && sb.size() != 0) begin
            chk("out_data", idx, 32'(out_data), 32'(sb[0]));
            if (v.ordy) void'(sb.pop_front());
         end
         if (v.ear || v.ebr) sb.push_back(v.esel ? v.bd : v.ad);
      end
      @(posedge clk);
      #1;
      if (v.rst) sb.delete();
      prev_rst = v.rst;
   endtask

   task automatic step_args(input int idx, input logic rst, av, bv, ordy,
                            input logic [15:0] ad, bd, input logic esel, ear, ebr);
      vec_t v;
      v.rst = rst; v.av = av; v.bv = bv; v.ordy = ordy;
      v.ad = ad; v.bd = bd; v.esel = esel; v.ear = ear; v.ebr = ebr;
      step(v, idx);
   endtask

   initial begin
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
      a_data = '0; b_data = '0;

      // Reset held 2 cycles with both requesters valid
      add(1,1,1,1, 16'h1111,16'h2222, 0,0,0);
      add(1,1,1,1, 16'h1111,16'h2222, 0,0,0);
      // Lone A for 6 cycles: never blocked by the burst limit (saturates at 4)
      for (int i = 0; i < 6; i++) add(0,1,0,1, 16'h1234,16'h0000, 0,1,0);
      // Contention: A's burst is saturated, so B wins the first tie -> BBBBAAAABBBB
      for (int i = 0; i < 12; i++) begin
         logic gb;
         gb = ((i / 4) % 2) == 0;
         add(0,1,1,1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), gb, !gb, gb);
      end
      // Backpressure: capture BEEF (A owner, cnt 1), stall 3 cycles, resume to A
      add(0,1,0,1, 16'hBEEF,16'h0000, 0,1,0);
      for (int i = 0; i < 3; i++) add(0,1,1,0, 16'hC000,16'hD000, 0,0,0);
      add(0,1,1,1, 16'hC001,16'hD001, 0,1,0);
      // Switch mid-burst: A had 2 grants, A drops, B takes 4, then A wins
      add(0,0,1,1, 16'h0000,16'hE001, 1,0,1);
      for (int i = 2; i <= 4; i++) add(0,1,1,1, 16'hA000 + 16'(i),16'hE000 + 16'(i), 1,0,1);
      add(0,1,1,1, 16'hA005,16'hE005, 0,1,0);
      add(0,1,1,1, 16'hA006,16'hE006, 0,1,0);
      // Reset while a word is held; it must never be emitted
      add(1,1,1,0, 16'hA007,16'hE007, 0,0,0);
      add(0,0,0,1, 16'h0000,16'h0000, 0,0,0);
      add(0,0,0,1, 16'h0000,16'h0000, 0,0,0);
      // Lone B, then idle: select stays on B while idle
      add(0,0,1,1, 16'h0000,16'hF001, 1,0,1);
      add(0,0,0,1, 16'h0000,16'h0000, 1,0,0);
      add(0,0,0,1, 16'h0000,16'h0000, 1,0,0);
      // Reset with grant-eligible inputs: readys forced low, nothing captured
      add(1,0,1,1, 16'h0000,16'hF002, 0,0,0);
      add(0,0,0,1, 16'h0000,16'h0000, 0,0,0);

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // Burst counter frozen under backpressure: A at 3 grants must still be
      // preferred after the stall, gets its 4th, then B takes over.
      step_args(100, 0,1,0,1, 16'h1A01,16'h0000, 0,1,0);
      step_args(101, 0,1,0,1, 16'h1A02,16'h0000, 0,1,0);
      step_args(102, 0,1,0,1, 16'h1A03,16'h0000, 0,1,0);
      step_args(103, 0,1,1,0, 16'h1A04,16'h2B04, 0,0,0);
      step_args(104, 0,1,1,0, 16'h1A04,16'h2B04, 0,0,0);
      step_args(105, 0,1,1,1, 16'h1A04,16'h2B04, 0,1,0);
      step_args(106, 0,1,1,1, 16'h1A05,16'h2B05, 1,0,1);
      // Drain
      step_args(107, 0,0,0,1, 16'h0000,16'h0000, 1,0,0);
      step_args(108, 0,0,0,1, 16'h0000,16'h0000, 1,0,0);
      chk("sb_empty", 109, 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
